reflet_vga_bitmap_filler: RTL and testbench
===========================================

// Module: reflet_VGA_bitmap_filler
// PURPOSE
//  Next-generation frame-buffer bitmap: N-channel pixel store at reduced resolution, with a registered read port for the VGA scanout side.
//  Adds a valid/ready single-pixel write port and a hardware rectangle-fill engine (one pixel per clock).
//  Optional power-up clear sweeps the whole memory after reset.
//  Sits between the drawing logic (CPU/GPU side) and the VGA timing/scanout path.
// PARAMETERS
//  h_size        640  visible pixels per line (full resolution)
//  v_line        480  visible lines (full resolution)
//  color_depth   8    bits per channel
//  channels      4    channels per pixel; packed {ch[channels-1],...,ch0}, ch0 in LSBs
//  bit_reduction 0    resolution divided by 2**bit_reduction on both axes
//  ram_resetable 0    1: every reset is followed by a hardware clear of all pixels to 0
// PORTS
//  clk          in   1     system clock, all logic on rising edge
//  reset        in   1     synchronous, active-high reset
//  wr_valid     in   1     single-pixel write request
//  wr_ready     out  1     write port can accept (transfer = wr_valid & wr_ready)
//  h_pixel_in   in   HW    write column, HW = $clog2(h_size)-bit_reduction
//  v_pixel_in   in   VW    write line,   VW = $clog2(v_line)-bit_reduction
//  color_in     in   CW    write pixel,  CW = channels*color_depth
//  fill_start   in   1     pulse: start rectangle fill (sampled only in IDLE)
//  fill_h0/fill_h1 in HW   first/last column (inclusive)
//  fill_v0/fill_v1 in VW   first/last line (inclusive)
//  fill_color   in   CW    fill pixel value
//  busy         out  1     fill or clear in progress
//  fill_done    out  1     one-cycle pulse when a fill (not clear) completes
//  h_pixel_out  in   HW    read column
//  v_pixel_out  in   VW    read line
//  color_out    out  CW    read pixel, 1-cycle latency, registered
// BEHAVIOUR
//  Geometry: HE=h_size>>bit_reduction, VE=v_line>>bit_reduction; addr = v*HE + h; depth HE*VE words of CW bits.
//  Reset values: wr_ready=0, busy=0, fill_done=0, color_out=0; state = IDLE (ram_resetable=0) or CLEAR (=1).
//  Memory contents are untouched by reset itself. Reset mid-fill/clear aborts immediately; no further writes.
//  FSM states:
//   IDLE:  wr_ready=1. fill_start -> FILL, latching clipped corners and fill_color.
//   FILL:  writes one pixel per cycle, raster order (h0..h1 inner, v0..v1 outer). wr_ready=0, busy=1.
//          After the last pixel -> IDLE, with fill_done=1 for that one cycle.
//   CLEAR: writes 0 to addr 0..HE*VE-1, one per cycle, busy=1, wr_ready=0. -> IDLE, no fill_done.
//  Fill timing: start sampled at cycle 0; pixels written in cycles 1..N (N=W*H); busy high in cycles 1..N.
//   busy=0 and fill_done=1 in cycle N+1.
//  Clipping: h1 clamped to HE-1, v1 clamped to VE-1 at capture.
//   If h0>h1 or v0>v1 after clamping: no write, busy stays 0, fill_done pulses in cycle 1.
//  Pixel write: in IDLE, wr_valid writes color_in at the coordinate that cycle.
//   h>=HE or v>=VE: transfer still completes (accepted) but nothing is written.
//  Simultaneous wr_valid and fill_start in IDLE: the pixel is written in cycle 0; the fill follows per fill timing.
//   The fill may overwrite that pixel.
//  wr_valid while wr_ready=0: not accepted; the requester holds it (valid/ready rule).
//  fill_start outside IDLE: ignored.
//  Read: color_out <= mem[read addr] every cycle, including during FILL/CLEAR.
//   Same-cycle read and write to one address returns the OLD data.
//   Out-of-range read coordinates return 0.
//  Address arithmetic is done at the width of $clog2(HE*VE); no wrap between lines.
// TESTING
//  1 ram_resetable=1, HE=4,VE=2 (h_size=8,v_line=4,bit_reduction=1): reset 1 cycle -> busy high exactly 8 cycles,
//    wr_ready=0 meanwhile; every read then returns 0.
//  2 IDLE write (3,1)=0xAABBCCDD -> read (3,1) gives 0xAABBCCDD next cycle; same-cycle read returns old value.
//  3 fill h0=1,h1=2,v0=0,v1=1, color 0x11223344 -> busy cycles 1..4, fill_done cycle 5.
//    Pixels (1,0),(2,0),(1,1),(2,1) = fill; (0,0),(3,1) unchanged.
//  4 fill h0=2,h1=1 -> no write, busy never high, fill_done at cycle 1. Fill h1=15 on HE=4 clamps to column 3.
//  5 wr_valid held during fill -> wr_ready=0 until the done cycle; the write lands once back in IDLE.
//    wr_valid+fill_start together -> pixel written, then covered by fill.
//  6 reset asserted mid-fill (cycle 2 of 4) -> busy=0, fill_done=0 next cycle; remaining pixels keep old values.

Source files
------------

// File: rtl/reflet_vga_bitmap_filler.sv
// Frame-buffer bitmap with a valid/ready pixel write port, a one-pixel-per-clock
// rectangle fill engine, an optional post-reset clear sweep, and a registered
// read port for the VGA scanout side.
module reflet_vga_bitmap_filler #(
  parameter int h_size        = 640,
  parameter int v_line        = 480,
  parameter int color_depth   = 8,
  parameter int channels      = 4,
  parameter int bit_reduction = 0,
  parameter int ram_resetable = 0,
  localparam int HW = $clog2(h_size) - bit_reduction,
  localparam int VW = $clog2(v_line) - bit_reduction,
  localparam int CW = channels * color_depth
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [HW-1:0] h_pixel_in,
  input  logic [VW-1:0] v_pixel_in,
  input  logic [CW-1:0] color_in,
  input  logic          fill_start,
  input  logic [HW-1:0] fill_h0,
  input  logic [HW-1:0] fill_h1,
  input  logic [VW-1:0] fill_v0,
  input  logic [VW-1:0] fill_v1,
  input  logic [CW-1:0] fill_color,
  output logic          busy,
  output logic          fill_done,
  input  logic [HW-1:0] h_pixel_out,
  input  logic [VW-1:0] v_pixel_out,
  output logic [CW-1:0] color_out
);

  localparam int HE    = h_size >> bit_reduction;
  localparam int VE    = v_line >> bit_reduction;
  localparam int DEPTH = HE * VE;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [HW-1:0] HMAX = HW'(HE - 1);
  localparam logic [VW-1:0] VMAX = VW'(VE - 1);
  localparam logic [AW-1:0] AMAX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, FILL, CLEAR} state_t;

  // Linear address of a pixel; callers guarantee h < HE and v < VE.
  function automatic logic [AW-1:0] addr_of(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return AW'(v) * AW'(HE) + AW'(h);
  endfunction

  function automatic logic in_range(input logic [HW-1:0] h, input logic [VW-1:0] v);
    return (h <= HMAX) && (v <= VMAX);
  endfunction

  logic [CW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic [HW-1:0] h_q, h_d, h0_q, h0_d, h1_q, h1_d;
  logic [VW-1:0] v_q, v_d, v1_q, v1_d;
  logic [CW-1:0] col_q, col_d;
  logic [AW-1:0] clr_q, clr_d;
  logic          fill_done_q, fill_done_d;
  logic [CW-1:0] color_out_q, color_out_d;

  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [CW-1:0] mem_wdata;
  logic [HW-1:0] h1_clip;
  logic [VW-1:0] v1_clip;
  logic          fill_empty;

  // Reset holds the write port closed and masks busy while it is asserted.
  assign wr_ready  = (state_q == IDLE) && !reset;
  assign busy      = (state_q != IDLE) && !reset;
  assign fill_done = fill_done_q;
  assign color_out = color_out_q;

  // Clip the requested rectangle to the bitmap and detect an empty result.
  always_comb begin
    h1_clip    = (fill_h1 > HMAX) ? HMAX : fill_h1;
    v1_clip    = (fill_v1 > VMAX) ? VMAX : fill_v1;
    fill_empty = (fill_h0 > h1_clip) || (fill_v0 > v1_clip);
  end

  // Next-state logic and the single memory write port shared by all sources.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    v1_d        = v1_q;
    col_d       = col_q;
    clr_d       = clr_q;
    fill_done_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = addr_of(h_pixel_in, v_pixel_in);
    mem_wdata   = color_in;
    unique case (state_q)
      IDLE: begin
        // Out-of-range pixels are still accepted, just not stored.
        mem_we = wr_valid && wr_ready && in_range(h_pixel_in, v_pixel_in);
        if (fill_start) begin
          if (fill_empty) begin
            fill_done_d = 1'b1;
          end else begin
            state_d = FILL;
            h_d     = fill_h0;
            v_d     = fill_v0;
            h0_d    = fill_h0;
            h1_d    = h1_clip;
            v1_d    = v1_clip;
            col_d   = fill_color;
          end
        end
      end
      FILL: begin
        mem_we    = 1'b1;
        mem_waddr = addr_of(h_q, v_q);
        mem_wdata = col_q;
        if (h_q == h1_q) begin
          h_d = h0_q;
          if (v_q == v1_q) begin
            state_d     = IDLE;
            fill_done_d = 1'b1;
          end else begin
            v_d = v_q + VW'(1);
          end
        end else begin
          h_d = h_q + HW'(1);
        end
      end
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_q;
        mem_wdata = '0;
        if (clr_q == AMAX) begin
          state_d = IDLE;
          clr_d   = '0;
        end else begin
          clr_d = clr_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // A reset edge aborts any pending write immediately.
    if (reset) mem_we = 1'b0;
  end

  // Registered read; same-cycle write to the address is not forwarded.
  always_comb begin
    color_out_d = '0;
    if (in_range(h_pixel_out, v_pixel_out)) color_out_d = mem[addr_of(h_pixel_out, v_pixel_out)];
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= (ram_resetable != 0) ? CLEAR : IDLE;
      clr_q       <= '0;
      fill_done_q <= 1'b0;
      color_out_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      fill_done_q <= fill_done_d;
      color_out_q <= color_out_d;
    end
  end

  // Fill walker and latched rectangle; only meaningful while in FILL.
  always_ff @(posedge clk) begin
    h_q   <= h_d;
    v_q   <= v_d;
    h0_q  <= h0_d;
    h1_q  <= h1_d;
    v1_q  <= v1_d;
    col_q <= col_d;
  end

  // Pixel store; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_reflet_vga_bitmap_filler.sv
// Scoreboard bench: two instances share all inputs, one with the post-reset
// clear (u_clr) and one without (u_nclr). h_size=9 keeps HE=4 while giving a
// 3-bit column so over-range columns can be driven.
module tb_reflet_vga_bitmap_filler;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_valid;
  logic [2:0]  h_pixel_in;
  logic [0:0]  v_pixel_in;
  logic [31:0] color_in;
  logic        fill_start;
  logic [2:0]  fill_h0, fill_h1;
  logic [0:0]  fill_v0, fill_v1;
  logic [31:0] fill_color;
  logic [2:0]  h_pixel_out;
  logic [0:0]  v_pixel_out;

  logic        wr_ready1, busy1, fill_done1;
  logic [31:0] color_out1;
  logic        wr_ready0, busy0, fill_done0;
  logic [31:0] color_out0;

  always #5 clk = ~clk;

  reflet_vga_bitmap_filler #(
    .h_size(9), .v_line(4), .color_depth(8), .channels(4), .bit_reduction(1), .ram_resetable(1)
  ) u_clr (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready1),
    .h_pixel_in(h_pixel_in), .v_pixel_in(v_pixel_in), .color_in(color_in),
    .fill_start(fill_start), .fill_h0(fill_h0), .fill_h1(fill_h1),
    .fill_v0(fill_v0), .fill_v1(fill_v1), .fill_color(fill_color),
    .busy(busy1), .fill_done(fill_done1),
    .h_pixel_out(h_pixel_out), .v_pixel_out(v_pixel_out), .color_out(color_out1)
  );

  reflet_vga_bitmap_filler #(
    .h_size(9), .v_line(4), .color_depth(8), .channels(4), .bit_reduction(1), .ram_resetable(0)
  ) u_nclr (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready0),
    .h_pixel_in(h_pixel_in), .v_pixel_in(v_pixel_in), .color_in(color_in),
    .fill_start(fill_start), .fill_h0(fill_h0), .fill_h1(fill_h1),
    .fill_v0(fill_v0), .fill_v1(fill_v1), .fill_color(fill_color),
    .busy(busy0), .fill_done(fill_done0),
    .h_pixel_out(h_pixel_out), .v_pixel_out(v_pixel_out), .color_out(color_out0)
  );

  typedef struct {
    string       name;
    bit          nclr;
    logic [2:0]  exp;   // {busy, wr_ready, fill_done}
  } ct_t;

  typedef struct {
    string       name;
    bit          nclr;
    logic [31:0] exp;
  } rd_t;

  ct_t ctq[$];
  rd_t rdq[$];
  int  ct_n = 0;
  int  rd_n = 0;
  int  rd_pend = 0;
  int  tests = 0;
  int  fails = 0;

  // Read responses appear one edge after the address is presented.
  always @(posedge clk) rd_pend <= rd_n;

  // Monitor: pop and compare whatever the stimulus scheduled for this cycle.
  ct_t         c;
  rd_t         r;
  logic [2:0]  act_ct;
  logic [31:0] act_rd;
  always @(negedge clk) begin
    for (int i = 0; i < ct_n; i++) begin
      tests++;
      if (ctq.size() == 0) begin
        fails++;
        $display("FAIL ctrl_queue_empty: got no entry required one");
      end else begin
        c = ctq.pop_front();
        act_ct = c.nclr ? {busy0, wr_ready0, fill_done0} : {busy1, wr_ready1, fill_done1};
        if (act_ct !== c.exp) begin
          fails++;
          $display("FAIL %s: {busy,wr_ready,fill_done} got %b required %b", c.name, act_ct, c.exp);
        end
      end
    end
    for (int i = 0; i < rd_pend; i++) begin
      tests++;
      if (rdq.size() == 0) begin
        fails++;
        $display("FAIL read_queue_empty: got no entry required one");
      end else begin
        r = rdq.pop_front();
        act_rd = r.nclr ? color_out0 : color_out1;
        if (act_rd !== r.exp) begin
          fails++;
          $display("FAIL %s: color_out got %h required %h", r.name, act_rd, r.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    ct_n = 0;
    rd_n = 0;
  endtask

  task automatic chk(input string n, input bit nclr, input logic [2:0] e);
    ct_t t;
    t.name = n; t.nclr = nclr; t.exp = e;
    ctq.push_back(t);
    ct_n++;
  endtask

  task automatic rd(input string n, input bit nclr, input int h, input int v, input logic [31:0] e);
    rd_t t;
    h_pixel_out = 3'(h);
    v_pixel_out = 1'(v);
    t.name = n; t.nclr = nclr; t.exp = e;
    rdq.push_back(t);
    rd_n++;
  endtask

  task automatic wr(input int h, input int v, input logic [31:0] col);
    wr_valid   = 1'b1;
    h_pixel_in = 3'(h);
    v_pixel_in = 1'(v);
    color_in   = col;
  endtask

  task automatic fill(input int h0, input int h1, input int v0, input int v1, input logic [31:0] col);
    fill_start = 1'b1;
    fill_h0    = 3'(h0);
    fill_h1    = 3'(h1);
    fill_v0    = 1'(v0);
    fill_v1    = 1'(v1);
    fill_color = col;
  endtask

  initial begin
    reset = 1'b1; wr_valid = 1'b0; h_pixel_in = '0; v_pixel_in = '0; color_in = '0;
    fill_start = 1'b0; fill_h0 = '0; fill_h1 = '0; fill_v0 = '0; fill_v1 = '0;
    fill_color = '0; h_pixel_out = '0; v_pixel_out = '0;

    // Reset state
    tick();
    chk("rst_ctrl_clr", 0, 3'b000);
    chk("rst_ctrl_nclr", 1, 3'b000);
    rd("rst_color_out", 0, 0, 0, 32'h0);
    tick();

    // Post-reset clear: busy for exactly HE*VE = 8 cycles
    reset = 1'b0;
    chk("nclr_idle_after_reset", 1, 3'b010);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("clear_busy_%0d", i), 0, 3'b100);
      tick();
    end
    chk("clear_end", 0, 3'b010);
    for (int i = 0; i < 8; i++) begin
      rd($sformatf("cleared_%0d", i), 0, i % 4, i / 4, 32'h0);
      tick();
    end

    // Single-pixel write, same-cycle read sees old data
    wr(3, 1, 32'hAABBCCDD);
    rd("wr_same_cycle_old", 0, 3, 1, 32'h0);
    chk("idle_ready", 0, 3'b010);
    tick();
    wr(5, 0, 32'hDEADBEEF);
    rd("wr_readback", 0, 3, 1, 32'hAABBCCDD);
    tick();
    wr_valid = 1'b0;
    rd("oob_read", 0, 5, 0, 32'h0);
    tick();
    rd("oob_write_no_wrap", 0, 1, 1, 32'h0);
    tick();

    // Rectangle fill 2x2
    fill(1, 2, 0, 1, 32'h11223344);
    chk("fill_c0", 0, 3'b010);
    tick();
    fill_start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill_busy_c%0d", i), 0, 3'b100);
      tick();
    end
    chk("fill_done_c5", 0, 3'b011);
    tick();
    chk("fill_after_c6", 0, 3'b010);
    rd("fill_p10", 0, 1, 0, 32'h11223344); tick();
    rd("fill_p20", 0, 2, 0, 32'h11223344); tick();
    rd("fill_p11", 0, 1, 1, 32'h11223344); tick();
    rd("fill_p21", 0, 2, 1, 32'h11223344); tick();
    rd("fill_keep00", 0, 0, 0, 32'h0); tick();
    rd("fill_keep31", 0, 3, 1, 32'hAABBCCDD); tick();

    // Empty rectangle: done at cycle 1, never busy
    fill(2, 1, 0, 1, 32'h00000055);
    chk("empty_c0", 0, 3'b010);
    tick();
    fill_start = 1'b0;
    chk("empty_done_c1", 0, 3'b011);
    tick();
    chk("empty_c2", 0, 3'b010);
    rd("empty_keep20", 0, 2, 0, 32'h11223344); tick();
    rd("empty_keep11", 0, 1, 1, 32'h11223344); tick();

    // Column clamp: h1=7 becomes 3, a single pixel
    fill(3, 7, 0, 0, 32'h77777777);
    tick();
    fill_start = 1'b0;
    chk("clamp_busy_c1", 0, 3'b100);
    tick();
    chk("clamp_done_c2", 0, 3'b011);
    tick();
    rd("clamp_p30", 0, 3, 0, 32'h77777777); tick();
    rd("clamp_no_wrap01", 0, 0, 1, 32'h0); tick();
    rd("clamp_keep20", 0, 2, 0, 32'h11223344); tick();

    // Write with fill_start, then a write held through the fill
    wr(0, 1, 32'hCAFEF00D);
    fill(0, 0, 0, 1, 32'h99999999);
    chk("both_c0", 0, 3'b010);
    rd("both_old01", 0, 0, 1, 32'h0);
    tick();
    fill_start = 1'b0;
    wr(2, 1, 32'h0BADCAFE);
    chk("held_c1", 0, 3'b100);
    rd("both_pixel_written", 0, 0, 1, 32'hCAFEF00D);
    tick();
    chk("held_c2", 0, 3'b100);
    rd("held_not_yet", 0, 2, 1, 32'h11223344);
    tick();
    chk("held_done_c3", 0, 3'b011);
    tick();
    wr_valid = 1'b0;
    rd("both_fill00", 0, 0, 0, 32'h99999999); tick();
    rd("both_covered01", 0, 0, 1, 32'h99999999); tick();
    rd("held_landed21", 0, 2, 1, 32'h0BADCAFE); tick();

    // Reset in cycle 2 of a 4-pixel fill
    fill(0, 3, 1, 1, 32'hEEEEEEEE);
    tick();
    fill_start = 1'b0;
    chk("abort_busy_c1", 1, 3'b100);
    tick();
    reset = 1'b1;
    chk("abort_in_reset", 1, 3'b000);
    tick();
    reset = 1'b0;
    chk("abort_after", 1, 3'b010);
    chk("abort_clr_clearing", 0, 3'b100);
    rd("abort_p01", 1, 0, 1, 32'hEEEEEEEE); tick();
    rd("abort_p11", 1, 1, 1, 32'h11223344); tick();
    rd("abort_p21", 1, 2, 1, 32'h0BADCAFE); tick();
    rd("abort_p31", 1, 3, 1, 32'hAABBCCDD); tick();
    repeat (4) tick();
    chk("reclear_end", 0, 3'b010);
    rd("reclear_p31", 0, 3, 1, 32'h0);
    repeat (3) tick();

    tests++;
    if (ctq.size() != 0 || rdq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d/%0d left required 0/0", ctq.size(), rdq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
